// File: rtl/window_scheduler.sv
// Pipelined load-strobe cascade for the 1 s / 5 s / 30 s / 240 s window stages.
// Optional synchronous clear port clr_i is added when WINDOW_SCHED_CLEAR_EN is defined.
module window_scheduler #(
  parameter int SPS  = 250,
  parameter int N5   = 5,
  parameter int N30  = 6,
  parameter int N240 = 8,
  parameter int D1S  = 5
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       sample_valid_i,
`ifdef WINDOW_SCHED_CLEAR_EN
  input  logic       clr_i,
`endif
  output logic       ld_1s_o,
  output logic       ld_5s_o,
  output logic       ld_30s_o,
  output logic       ld_240s_o,
  output logic       out_valid_o,
  output logic [1:0] state_o,
  output logic [3:0] full_flags_o
);

  // state | meaning
  // IDLE  | no sample accepted since reset/clear
  // FILL  | samples flowing, 240 s stage not yet full
  // RUN   | 240 s stage full, out_valid pulses each 240 s load
  typedef enum logic [1:0] {IDLE = 2'b00, FILL = 2'b01, RUN = 2'b10} state_t;

  localparam int W1   = (SPS  > 1) ? $clog2(SPS)  : 1;
  localparam int W5   = (N5   > 1) ? $clog2(N5)   : 1;
  localparam int W30  = (N30  > 1) ? $clog2(N30)  : 1;
  localparam int FW1  = $clog2(D1S + 1);
  localparam int FW5  = $clog2(N5 + 1);
  localparam int FW30 = $clog2(N30 + 1);
  localparam int FW240 = $clog2(N240 + 1);

  localparam logic [W1-1:0]    C1_MAX   = W1'(SPS - 1);
  localparam logic [W5-1:0]    C5_MAX   = W5'(N5 - 1);
  localparam logic [W30-1:0]   C30_MAX  = W30'(N30 - 1);
  localparam logic [FW1-1:0]   F1_FULL  = FW1'(D1S);
  localparam logic [FW5-1:0]   F5_FULL  = FW5'(N5);
  localparam logic [FW30-1:0]  F30_FULL = FW30'(N30);
  localparam logic [FW240-1:0] F240_FULL = FW240'(N240);
  localparam logic [FW240-1:0] F240_LAST = FW240'(N240 - 1);

  logic clr;
`ifdef WINDOW_SCHED_CLEAR_EN
  assign clr = clr_i;
`else
  assign clr = 1'b0;
`endif

  state_t             state_q, state_d;
  logic [W1-1:0]      c1_q, c1_d;
  logic [W5-1:0]      c5_q, c5_d;
  logic [W30-1:0]     c30_q, c30_d;
  logic [FW1-1:0]     fill1_q, fill1_d;
  logic [FW5-1:0]     fill5_q, fill5_d;
  logic [FW30-1:0]    fill30_q, fill30_d;
  logic [FW240-1:0]   fill240_q, fill240_d;
  logic               ld1_q, ld1_d, wrap1_q, wrap1_d;
  logic               ld5_q, ld5_d, wrap5_q, wrap5_d;
  logic               ld30_q, ld30_d, wrap30_q, wrap30_d;
  logic               ld240_q, ld240_d, ov_q, ov_d;
  logic               accept, last_load;

  always_comb begin
    accept    = sample_valid_i & ~en_i;
    last_load = ld240_q & (fill240_q >= F240_LAST);

    c1_d      = c1_q;
    c5_d      = c5_q;
    c30_d     = c30_q;
    fill1_d   = fill1_q;
    fill5_d   = fill5_q;
    fill30_d  = fill30_q;
    fill240_d = fill240_q;
    state_d   = state_q;

    // wrapN flags ride one stage ahead of the strobe they will trigger
    ld1_d    = accept;
    wrap1_d  = accept & (c1_q == C1_MAX);
    ld5_d    = wrap1_q;
    wrap5_d  = wrap1_q & (c5_q == C5_MAX);
    ld30_d   = wrap5_q;
    wrap30_d = wrap5_q & (c30_q == C30_MAX);
    ld240_d  = wrap30_q;
    ov_d     = last_load;

    if (accept)  c1_d  = (c1_q == C1_MAX)   ? '0 : c1_q + W1'(1);
    if (wrap1_q) c5_d  = (c5_q == C5_MAX)   ? '0 : c5_q + W5'(1);
    if (wrap5_q) c30_d = (c30_q == C30_MAX) ? '0 : c30_q + W30'(1);

    if (ld1_q   && fill1_q   != F1_FULL)   fill1_d   = fill1_q + FW1'(1);
    if (ld5_q   && fill5_q   != F5_FULL)   fill5_d   = fill5_q + FW5'(1);
    if (ld30_q  && fill30_q  != F30_FULL)  fill30_d  = fill30_q + FW30'(1);
    if (ld240_q && fill240_q != F240_FULL) fill240_d = fill240_q + FW240'(1);

    case (state_q)
      IDLE:    if (accept) state_d = FILL;
      FILL:    if (last_load) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase

    if (clr) begin
      c1_d = '0; c5_d = '0; c30_d = '0;
      fill1_d = '0; fill5_d = '0; fill30_d = '0; fill240_d = '0;
      ld1_d = 1'b0; wrap1_d = 1'b0; ld5_d = 1'b0; wrap5_d = 1'b0;
      ld30_d = 1'b0; wrap30_d = 1'b0; ld240_d = 1'b0; ov_d = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      c1_q <= '0; c5_q <= '0; c30_q <= '0;
      fill1_q <= '0; fill5_q <= '0; fill30_q <= '0; fill240_q <= '0;
      ld1_q <= 1'b0; wrap1_q <= 1'b0; ld5_q <= 1'b0; wrap5_q <= 1'b0;
      ld30_q <= 1'b0; wrap30_q <= 1'b0; ld240_q <= 1'b0; ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      c1_q <= c1_d; c5_q <= c5_d; c30_q <= c30_d;
      fill1_q <= fill1_d; fill5_q <= fill5_d; fill30_q <= fill30_d; fill240_q <= fill240_d;
      ld1_q <= ld1_d; wrap1_q <= wrap1_d; ld5_q <= ld5_d; wrap5_q <= wrap5_d;
      ld30_q <= ld30_d; wrap30_q <= wrap30_d; ld240_q <= ld240_d; ov_q <= ov_d;
    end
  end

  assign ld_1s_o      = ld1_q;
  assign ld_5s_o      = ld5_q;
  assign ld_30s_o     = ld30_q;
  assign ld_240s_o    = ld240_q;
  assign out_valid_o  = ov_q;
  assign state_o      = state_q;
  assign full_flags_o = {fill240_q == F240_FULL, fill30_q == F30_FULL,
                         fill5_q == F5_FULL, fill1_q == F1_FULL};

endmodule

// File: tb/tb_window_scheduler.sv
// Scoreboard bench for window_scheduler: stimulus pushes expected strobe cycles,
// a negedge monitor pops and compares whenever a strobe is seen.
module tb_window_scheduler;
  localparam int SPS = 4, N5 = 2, N30 = 2, N240 = 2, D1S = 2;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, sv = 1'b0, clr = 1'b0;
  logic ld1, ld5, ld30, ld240, ov;
  logic [1:0] st;
  logic [3:0] ff;

  window_scheduler #(.SPS(SPS), .N5(N5), .N30(N30), .N240(N240), .D1S(D1S)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .sample_valid_i(sv),
`ifdef WINDOW_SCHED_CLEAR_EN
    .clr_i(clr),
`endif
    .ld_1s_o(ld1), .ld_5s_o(ld5), .ld_30s_o(ld30), .ld_240s_o(ld240),
    .out_valid_o(ov), .state_o(st), .full_flags_o(ff)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int expq[5][$];
  int seen[5];
  int n_acc = 0;
  int n_pass = 0, n_chk = 0;
  string nm[5] = '{"ld_1s", "ld_5s", "ld_30s", "ld_240s", "out_valid"};

  task automatic chk(input string name, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, got, want);
  endtask

  always @(negedge clk) begin
    logic [4:0] s;
    s = {ov, ld240, ld30, ld5, ld1};
    for (int i = 0; i < 5; i++) begin
      if (s[i]) begin
        seen[i]++;
        if (expq[i].size() == 0) chk({nm[i], " unexpected at cycle"}, cyc, -1);
        else chk({nm[i], " cycle"}, cyc, expq[i].pop_front());
      end
    end
  end

  task automatic model_accept(input int t);
    n_acc++;
    expq[0].push_back(t);
    if (n_acc % SPS == 0) expq[1].push_back(t + 1);
    if (n_acc % (SPS * N5) == 0) expq[2].push_back(t + 2);
    if (n_acc % (SPS * N5 * N30) == 0) begin
      expq[3].push_back(t + 3);
      if (n_acc >= SPS * N5 * N30 * N240) expq[4].push_back(t + 4);
    end
  endtask

  task automatic purge_after(input int t);
    for (int i = 0; i < 5; i++)
      while (expq[i].size() > 0 && expq[i][expq[i].size() - 1] > t) void'(expq[i].pop_back());
  endtask

  task automatic clear_seen();
    for (int i = 0; i < 5; i++) seen[i] = 0;
  endtask

  // drives one cycle of inputs; the next posedge samples them
  task automatic step(input logic s, input logic e, input logic c);
    sv = s; en = e; clr = c;
    if (clr) begin
      purge_after(cyc);
      n_acc = 0;
    end else if (s && !e) begin
      model_accept(cyc + 1);
    end
    @(posedge clk); #1;
    sv = 1'b0; clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, en, 1'b0);
  endtask

  task automatic check_zero(input string name);
    chk({name, " strobes"}, int'({ov, ld240, ld30, ld5, ld1}), 0);
    chk({name, " state"}, int'(st), 0);
    chk({name, " full_flags"}, int'(ff), 0);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk); #1;
    rst_n = 1'b0; en = 1'b0; sv = 1'b0; clr = 1'b0;
    purge_after(-1);
    n_acc = 0;
    clear_seen();
    #1 check_zero({name, " in reset"});
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic end_scn(input string name);
    idle(8);
    for (int i = 0; i < 5; i++) chk({name, " pending ", nm[i]}, expq[i].size(), 0);
  endtask

  initial begin
    #1 check_zero("power-on reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);
    check_zero("after release");

    // A: three accepts
    clear_seen();
    step(1, 0, 0);
    chk("A state after first accept", int'(st), 1);
    idle(1); step(1, 0, 0); idle(1); step(1, 0, 0);
    end_scn("A");
    chk("A ld_1s count", seen[0], 3);
    chk("A ld_5s count", seen[1], 0);
    chk("A full_flags", int'(ff), 4'b0001);

    // B: 32 accepts, one every 3 cycles
    do_reset("B");
    for (int i = 0; i < 32; i++) begin step(1, 0, 0); idle(2); end
    end_scn("B");
    chk("B ld_5s count", seen[1], 8);
    chk("B ld_30s count", seen[2], 4);
    chk("B ld_240s count", seen[3], 2);
    chk("B out_valid count", seen[4], 1);
    chk("B state", int'(st), 2);
    chk("B full_flags", int'(ff), 4'b1111);

    // C: 48 back-to-back accepts
    do_reset("C");
    repeat (48) step(1, 0, 0);
    end_scn("C");
    chk("C ld_5s count", seen[1], 12);
    chk("C ld_30s count", seen[2], 6);
    chk("C ld_240s count", seen[3], 3);
    chk("C out_valid count", seen[4], 2);

    // D: enable held high with sample_valid toggling
    do_reset("D");
    repeat (3) begin step(1, 0, 0); idle(1); end
    step(1, 0, 0);
    for (int i = 0; i < 10; i++) step((i % 2) == 0, 1'b1, 1'b0);
    chk("D in-flight ld_5s", seen[1], 1);
    chk("D ld_1s while frozen", seen[0], 4);
    step(0, 0, 0);
    repeat (4) step(1, 0, 0);
    end_scn("D");
    chk("D ld_1s count", seen[0], 8);
    chk("D ld_5s count", seen[1], 2);

    // E: reset in the cycle after accept 16
    do_reset("E pre");
    repeat (16) step(1, 0, 0);
    do_reset("E mid-cascade");
    idle(8);
    chk("E strobes after reset", seen[0] + seen[1] + seen[2] + seen[3] + seen[4], 0);
    check_zero("E after release");

`ifdef WINDOW_SCHED_CLEAR_EN
    // F: clear coincident with accept 4
    do_reset("F");
    repeat (3) step(1, 0, 0);
    step(1, 0, 1);
    chk("F state after clr", int'(st), 0);
    idle(4);
    chk("F ld_5s after clr", seen[1], 0);
    repeat (4) step(1, 0, 0);
    end_scn("F");
    chk("F ld_5s count", seen[1], 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1);
  end
endmodule

// File: doc/window_scheduler.md
# window_scheduler

Sequencing controller for the multi-rate sliding-window datapath of 1 s, 5 s, 30 s and 240 s windows. It counts accepted input samples and issues one-cycle load strobes to each window stage's shift register. Each strobe is issued exactly one cycle after the strobe that completes the preceding stage's sum. It tracks fill level per stage and flags when the final output is valid. The block replaces per-stage free-running counters with one pipelined cascade, so every stage loads an already-settled sum.

## Interface
- `SPS`, 250, samples per 1 s window boundary.
- `N5`, 5, 1 s loads per 5 s load.
- `N30`, 6, 5 s loads per 30 s load.
- `N240`, 8, 30 s loads per 240 s load; also the depth of the 240 s stage.
- `D1S`, 5, depth of the 1 s stage (fill tracking only).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  active-low enable; high freezes sample acceptance.
- `sample_valid`  in  1  one-cycle pulse per new input sample.
- `ld_1s`, `ld_5s`, `ld_30s`, `ld_240s`  out  1 each  one-cycle load strobes to the stage shift registers.
- `out_valid`  out  1  one-cycle pulse: the 240 s sum is valid this cycle.
- `state`  out  2  00 IDLE, 01 FILL, 10 RUN.
- `full_flags`  out  4  {240s, 30s, 5s, 1s} stage-full flags.

## Operation
- Accept condition: `sample_valid & ~en`. With `en` high, samples are ignored and counters hold.
- Counters, each `$clog2(N)` bits and wrapping N-1 → 0:
  - `c1` counts accepted samples modulo SPS.
  - `c5` counts `ld_5s` events modulo N5.
  - `c30` counts `ld_30s` events modulo N30.
- Cascade, where T is the accept cycle:
  - `ld_1s` at T+1 on every accept.
  - `ld_5s` at T+2 if `c1` was SPS-1 at T.
  - `ld_30s` at T+3 if that `ld_5s` wrapped `c5`.
  - `ld_240s` at T+4 if that `ld_30s` wrapped `c30`.
  - `out_valid` at T+5 if `ld_240s` fired and the 240 s stage was already full, or became full on that load.
- Strobes in flight always complete, even if `en` rises after T.
- Fill counters are saturating, one per stage. Depths are D1S, N5, N30 and N240; each increments on its stage's `ld_*`. A `full_flags` bit sets when its fill counter reaches depth and stays set until reset or clear.
- State machine:
  - IDLE → FILL on the first accept.
  - FILL → RUN in the cycle `full_flags[3]` sets.
  - RUN holds.
- Back-to-back accepts on consecutive cycles are legal. Each propagates independently down the pipeline, and no strobe is dropped or merged.

## Timing
- Reset (`rst` low, asynchronous) clears all counters, fill counters and pipeline registers.
  - Every output is 0 and `state`=IDLE.
  - Outputs stay 0 until the first accept after `rst` rises.
- Reset asserted mid-cascade kills in-flight strobes immediately; none appear after release.
- Latency from accept to `ld_1s` is 1 cycle; each further stage adds 1 cycle.
- Period of `out_valid` in RUN is SPS·N5·N30 accepted samples.
- First `out_valid` follows accepted sample number SPS·N5·N30·N240, at T+5.
- All strobes are registered outputs, with no combinational path from inputs.

## Configuration
- `WINDOW_SCHED_CLEAR_EN` defined:
  - Adds input port `clr` (1 bit, synchronous, active-high).
  - `clr` high zeroes counters, fill counters and pipeline registers on the next edge and sets `state`=IDLE.
  - `clr` has priority over a simultaneous accept, which is discarded.
- `WINDOW_SCHED_CLEAR_EN` undefined: the port is absent and behaviour is identical to `clr`=0.

## Test plan
All scenarios use SPS=4, N5=2, N30=2, N240=2, D1S=2 unless noted.
- Reset then 3 accepts:
  - `ld_1s` pulses 3 times, each 1 cycle after its accept.
  - No `ld_5s`; `state`=FILL after the first accept.
- 32 accepts, one every 3 cycles:
  - `ld_5s` fires 8 times, `ld_30s` 4 times, `ld_240s` 2 times.
  - Single `out_valid` 5 cycles after accept 32.
  - `state`=RUN and `full_flags`=1111 at that point.
- 48 accepts back-to-back, one per cycle:
  - Exactly 12 `ld_5s`, 6 `ld_30s`, 3 `ld_240s` and 2 `out_valid`.
  - `out_valid` pulses follow accepts 32 and 48, each by 5 cycles.
- `en` high for 10 cycles with `sample_valid` toggling:
  - No counter change.
  - A strobe in flight from the accept just before `en` rose still appears on schedule.
- `rst` low in the cycle after accept 16, the accept that fires `ld_240s`:
  - No `ld_5s`, `ld_30s` or `ld_240s` emerges.
  - All outputs read 0 and `state`=IDLE.
- With `WINDOW_SCHED_CLEAR_EN` defined, `clr` coincident with accept 4:
  - No `ld_1s` or `ld_5s` follows, and `state`=IDLE.
  - The next 4 accepts produce the first `ld_5s`.
